// File: rtl/spi_write_arbiter_if.sv
// Requester and SPI pin bundle for spi_write_arbiter.
// slave = arbiter view, master = requester/pin-side view.
interface spi_write_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [9*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 spi_sclk;
  logic                 spi_mosi;
  logic                 spi_cs_n;
  logic                 spi_dc;
  logic                 busy;
  logic [IDX_W-1:0]     last_grant;

  modport slave (
    input  req_valid, req_data,
    output req_ready, spi_sclk, spi_mosi, spi_cs_n, spi_dc, busy, last_grant
  );

  modport master (
    output req_valid, req_data,
    input  req_ready, spi_sclk, spi_mosi, spi_cs_n, spi_dc, busy, last_grant
  );
endinterface

// File: rtl/spi_write_arbiter.sv
// Round-robin arbiter feeding a mode-0, MSB-first 9-bit (D/C + byte) SPI writer.
// Define SPI_CS_HOLD_EN to let a persistent winner chain frames without raising cs_n.
module spi_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int CLK_DIV = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               CLK,
  input  logic               RST_N,
  spi_write_arbiter_if.slave bus
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       phase_q, phase_d;
  logic [8:0]       word_q, word_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;

  logic [8:0]       req_word [NUM_REQ];
  logic             any_valid;
  logic [IDX_W-1:0] win_idx;
  logic             grant_fire;
  logic             div_end;
  logic [7:0]       payload;
  logic [2:0]       bit_sel;
  logic             mosi;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_word[gi]      = bus.req_data[9*gi +: 9];
      assign bus.req_ready[gi] = grant_fire && (win_idx == IDX_W'(gi));
    end
  endgenerate

  // Scan from farthest to nearest offset so the nearest valid requester after last_grant wins.
  always_comb begin
    int cand;
    any_valid = 1'b0;
    win_idx   = last_grant_q;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = int'(last_grant_q) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (bus.req_valid[IDX_W'(cand)]) begin
        any_valid = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  assign div_end = (div_q == DIV_LAST);

  always_comb begin
    grant_fire = 1'b0;
    if (RST_N && any_valid) begin
      if (state_q == ST_IDLE) begin
        grant_fire = 1'b1;
      end
`ifdef SPI_CS_HOLD_EN
      else if (state_q == ST_HOLD && div_end && win_idx == last_grant_q) begin
        grant_fire = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    phase_d      = phase_q;
    word_d       = word_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_fire) begin
          word_d       = req_word[win_idx];
          last_grant_d = win_idx;
          div_d        = '0;
          state_d      = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (div_end) begin
          div_d   = '0;
          phase_d = 5'd0;
          state_d = ST_SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (div_end) begin
          div_d = '0;
          if (phase_q == 5'd15) state_d = ST_HOLD;
          else                  phase_d = phase_q + 5'd1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (div_end) begin
          div_d = '0;
          // grant_fire can only be set here when chaining is compiled in.
          if (grant_fire) begin
            word_d       = req_word[win_idx];
            last_grant_d = win_idx;
            state_d      = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      div_q        <= '0;
      phase_q      <= 5'd0;
      word_q       <= 9'd0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      phase_q      <= phase_d;
      word_q       <= word_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Each bit spans one low and one high half-phase, so it only moves on falling edges.
  assign payload = word_q[7:0];
  assign bit_sel = 3'd7 - phase_q[3:1];

  always_comb begin
    mosi = 1'b0;
    case (state_q)
      ST_SETUP: mosi = payload[7];
      ST_SHIFT: mosi = payload[bit_sel];
      ST_HOLD:  mosi = payload[0];
      default:  mosi = 1'b0;
    endcase
  end

  assign bus.spi_mosi   = mosi;
  assign bus.spi_sclk   = (state_q == ST_SHIFT) && phase_q[0];
  assign bus.spi_cs_n   = (state_q == ST_IDLE);
  assign bus.spi_dc     = (state_q != ST_IDLE) && word_q[8];
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.last_grant = last_grant_q;
endmodule
